bcd_updown_counter: RTL and testbench
=====================================

// Module: bcd_updown_counter
// PURPOSE
//   Parametrised N-digit decimal (BCD) up/down counter with on-board timebase and 7-segment outputs.
//   Two selectable tick rates, key-controlled direction, synchronous load/clear, pause,
//   and a one-cycle wrap flag.
//   Top-level board block: the counter drives HEX displays and is also usable as a timed event source.
// PARAMETERS
//   NUM_DIGITS  2           number of BCD digits (1..8); count modulus = 10**NUM_DIGITS
//   SLOW_DIV    100000000   clk cycles per tick when speed_sel=1 (>=2)
//   FAST_DIV    50000000    clk cycles per tick when speed_sel=0 (>=2)
//   DIV_W       27          prescaler width; must satisfy 2**DIV_W >= max(SLOW_DIV,FAST_DIV)
// PORTS
//   clk        in   1              system clock
//   rst        in   1              asynchronous reset, active-low
//   speed_sel  in   1              0 = FAST_DIV tick, 1 = SLOW_DIV tick
//   key_up     in   1              level: count up on each tick
//   key_down   in   1              level: count down on each tick
//   pause      in   1              1 = freeze prescaler and count
//   clear      in   1              synchronous clear of count and prescaler
//   load       in   1              synchronous load of load_val
//   load_val   in   4*NUM_DIGITS   BCD value to load, digit 0 in [3:0]
//   bcd        out  4*NUM_DIGITS   current count, BCD, digit 0 in [3:0]
//   hex        out  7*NUM_DIGITS   active-low segments {g..a} per digit, digit 0 in [6:0]
//   tick       out  1              one-cycle pulse: prescaler terminal count
//   wrap       out  1              one-cycle pulse: count wrapped (max->0 up, 0->max down)
// BEHAVIOUR
//   Reset (rst=0, async): prescaler=0, bcd=0, tick=0, wrap=0; hex shows "0" on every digit.
//   Prescaler:
//   - counts 0..DIV-1, where DIV is selected by speed_sel.
//   - tick is registered and asserts the cycle after prescaler reaches DIV-1; prescaler then returns to 0.
//   - A change of speed_sel (vs. previous cycle) restarts the prescaler at 0 and suppresses tick that cycle.
//   Direction, sampled on the tick cycle:
//   - up   = key_up & ~key_down
//   - down = key_down & ~key_up
//   - both or neither = hold (no change, no wrap).
//   Count update:
//   - digit i updates only when every lower digit is at 9 (up) or 0 (down).
//   - up:   9->0 ripple.
//   - down: 0->9 ripple.
//   - bcd updates in the same cycle tick is high, so it is visible 1 cycle after tick.
//   wrap:
//   - asserted with the bcd update for up at all-9s->0, and for down at 0->all-9s.
//   - never asserted on load or clear.
//   Priority (highest first): rst > clear > load > pause > tick-driven count.
//   - clear: bcd=0 and prescaler=0 next cycle; tick=0, wrap=0.
//   - load: bcd=load_val, with any digit >9 forced to 0; prescaler unaffected; a coincident tick is discarded.
//   - pause: prescaler and bcd hold; tick=0; resuming continues from the held prescaler value.
//   hex is combinational from bcd; codes 0-9 are standard, and an impossible value >9 shows all segments off.
//   All outputs other than hex are registered. Async reset mid-count returns everything to the reset state.
// STRUCTURE
//   Package bcd_counter_pkg:
//   - typedef logic [3:0] bcd_t
//   - localparam logic [6:0] SEG_LUT[10], active-low patterns
//   - localparam logic [6:0] SEG_BLANK = 7'h7F
//   - function seg_encode(bcd_t)
//   Sub-module bcd_digit: one digit with inputs inc, dec, load, ld_val, clear and outputs q, at_max, at_min.
//   - Instantiate it NUM_DIGITS times via generate.
//   - Chain enable: en_i = tick & AND(at_max/at_min of digits < i).
//   Prescaler and direction logic live in the top module.
// TESTING  (bench overrides SLOW_DIV=8, FAST_DIV=4, NUM_DIGITS=2)
//   1. rst low 3 cycles, then high, keys idle -> bcd=00, hex=2x7'h40, tick pulses every 4 clk, bcd stays 00.
//   2. key_up=1, speed_sel=0 -> bcd 00,01..09,10 (ripple), ..., 99 -> 00 with wrap=1 for exactly 1 cycle.
//   3. From bcd=00, key_down=1 -> next tick gives bcd=99 with wrap=1; the following tick gives 98.
//   4. key_up=key_down=1 for 5 ticks -> bcd unchanged, wrap=0; toggle speed_sel mid-period -> tick period restarts (8 clk).
//   5. load=1 with load_val=8'h4C on a tick cycle -> bcd=40 (digit C forced to 0), no count, no wrap;
//      then clear=1 with load=1 -> bcd=00.
//   6. pause=1 for 20 clk during counting -> no tick, bcd frozen;
//      assert rst=0 asynchronously mid-cycle -> bcd=00 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types and 7-segment encoding for the BCD up/down counter.
// Pure declarations; no timing or flow control of its own.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input bcd_t v);
    if (v > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_LUT[v];
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear > load > inc > dec, wrapping 9->0 and 0->9.
// Latency 1 clk from control inputs to q; no backpressure, always accepts.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  logic clear,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic at_max,
  output logic at_min
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = 4'd0;
    end else if (load) begin
      // Non-decimal load values collapse to 0 rather than propagating garbage
      q_d = (ld_val > 4'd9) ? 4'd0 : ld_val;
    end else if (inc) begin
      q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == 4'd9);
  assign at_min = (q_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with two-rate prescaler, wrap flag and 7-seg decode.
// bcd/wrap update 1 clk after tick; no backpressure, control inputs act every cycle.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SLOW_DIV   = 100000000,
  parameter int FAST_DIV   = 50000000,
  parameter int DIV_W      = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    speed_sel,
  input  logic                    key_up,
  input  logic                    key_down,
  input  logic                    pause,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    tick,
  output logic                    wrap
);

  localparam logic [DIV_W-1:0] SLOW_TC = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_TC = DIV_W'(FAST_DIV - 1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             speed_q, speed_d;

  logic [NUM_DIGITS-1:0] inc, dec, at_max, at_min;
  bcd_t                  digit_q [NUM_DIGITS];

  logic             dir_up, dir_dn, cnt_en, up_run, dn_run;
  logic [DIV_W-1:0] term;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    speed_d = speed_sel;
    term    = speed_sel ? SLOW_TC : FAST_TC;
    if (clear) begin
      presc_d = '0;
    end else if (pause) begin
      presc_d = presc_q;
    end else if (speed_sel != speed_q) begin
      // Rate change restarts the period so the first tick at the new rate is a full one
      presc_d = '0;
    end else if (presc_q >= term) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    inc    = '0;
    dec    = '0;
    dir_up = key_up & ~key_down;
    dir_dn = key_down & ~key_up;
    cnt_en = tick_q & ~clear & ~load & ~pause;
    up_run = 1'b1;
    dn_run = 1'b1;
    // Digit i moves only when all lower digits are about to roll over
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc[i] = cnt_en & dir_up & up_run;
      dec[i] = cnt_en & dir_dn & dn_run;
      up_run = up_run & at_max[i];
      dn_run = dn_run & at_min[i];
    end
    wrap_d = cnt_en & ((dir_up & up_run) | (dir_dn & dn_run));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      speed_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      speed_q <= speed_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst),
      .inc    (inc[i]),
      .dec    (dec[i]),
      .load   (load),
      .clear  (clear),
      .ld_val (load_val[4*i +: 4]),
      .q      (digit_q[i]),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );
    assign bcd[4*i +: 4] = digit_q[i];
    assign hex[7*i +: 7] = seg_encode(digit_q[i]);
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed + random bench for bcd_updown_counter against an integer-count reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        speed_sel = 1'b0;
  logic        key_up = 1'b0;
  logic        key_down = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  bcd;
  logic [13:0] hex;
  logic        tick;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  // Reference model state: count as a plain integer 0..99
  int m_cnt = 0;
  int m_presc = 0;
  bit m_tick = 0;
  bit m_wrap = 0;
  bit m_speed = 0;

  logic [6:0] seg_tb [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_updown_counter #(.NUM_DIGITS(2), .SLOW_DIV(8), .FAST_DIV(4), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .speed_sel(speed_sel), .key_up(key_up), .key_down(key_down),
    .pause(pause), .clear(clear), .load(load), .load_val(load_val),
    .bcd(bcd), .hex(hex), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_speed = 0;
  endtask

  task automatic model_clock();
    int div, n_presc, n_cnt;
    bit n_tick, n_wrap, up, dn;
    if (!rst) begin
      model_reset();
      return;
    end
    div = speed_sel ? 8 : 4;
    n_presc = m_presc; n_cnt = m_cnt; n_tick = 0; n_wrap = 0;
    up = key_up && !key_down;
    dn = key_down && !key_up;
    if (clear) begin
      n_presc = 0;
      n_cnt = 0;
    end else begin
      if (pause) n_presc = m_presc;
      else if (speed_sel != m_speed) n_presc = 0;
      else if (m_presc >= div - 1) begin n_presc = 0; n_tick = 1; end
      else n_presc = m_presc + 1;
      if (load) n_cnt = from_load(load_val);
      else if (!pause && m_tick && up) begin n_cnt = (m_cnt + 1) % 100; n_wrap = (m_cnt == 99); end
      else if (!pause && m_tick && dn) begin n_cnt = (m_cnt + 99) % 100; n_wrap = (m_cnt == 0); end
    end
    m_presc = n_presc; m_cnt = n_cnt; m_tick = n_tick; m_wrap = n_wrap; m_speed = speed_sel;
  endtask

  task automatic compare();
    check("bcd", 32'(bcd), 32'(to_bcd(m_cnt)));
    check("tick", 32'(tick), 32'(m_tick));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("hex", 32'(hex), 32'({seg_tb[m_cnt / 10], seg_tb[m_cnt % 10]}));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int n, nw, k;
    bit seen;
    int held;

    // 1: reset, idle keys
    repeat (3) step();
    check("reset_bcd", 32'(bcd), 32'h00);
    check("reset_hex", 32'(hex), 32'h2040);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin step(); if (tick) n++; end
    check("idle_tick_count", n, 4);
    check("idle_bcd", 32'(bcd), 32'h00);

    // 2: count up through full wrap
    key_up = 1'b1;
    nw = 0;
    for (int i = 0; i < 410; i++) begin step(); if (wrap) nw++; end
    check("up_wrap_count", nw, 1);

    // 3: down from 00 wraps to 99, then 98
    clear = 1'b1; step(); clear = 1'b0;
    key_up = 1'b0; key_down = 1'b1;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin step(); if (wrap) seen = 1; end
    check("down_wrap_seen", 32'(seen), 32'd1);
    check("down_wrap_bcd", 32'(bcd), 32'h99);
    repeat (4) step();
    check("down_next_bcd", 32'(bcd), 32'h98);

    // 4: both keys hold; speed change restarts period
    key_up = 1'b1;
    nw = 0;
    for (int i = 0; i < 20; i++) begin step(); if (wrap) nw++; end
    check("both_hold_bcd", 32'(bcd), 32'h98);
    check("both_no_wrap", nw, 0);
    repeat (2) step();
    speed_sel = 1'b1;
    k = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin step(); if (tick) begin seen = 1; k = i; end end
    check("speed_restart_steps", k, 9);

    // 5: load on a tick cycle, then clear beats load
    key_down = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); if (tick) seen = 1; end
    check("load_tick_found", 32'(seen), 32'd1);
    load = 1'b1; load_val = 8'h4C;
    step();
    check("load_bcd", 32'(bcd), 32'h40);
    check("load_wrap", 32'(wrap), 32'd0);
    clear = 1'b1;
    step();
    check("clear_over_load", 32'(bcd), 32'h00);
    clear = 1'b0; load = 1'b0;

    // 6: pause freezes, then async reset mid-cycle
    speed_sel = 1'b0;
    repeat (14) step();
    pause = 1'b1;
    step();
    held = m_cnt;
    n = 0;
    for (int i = 0; i < 20; i++) begin step(); if (tick) n++; end
    check("pause_no_tick", n, 0);
    check("pause_frozen", 32'(bcd), 32'(to_bcd(held)));
    check("pause_nonzero", 32'(bcd != 8'h00), 32'd1);
    pause = 1'b0;
    repeat (6) step();
    #2 rst = 1'b0;
    #1;
    check("async_rst_bcd", 32'(bcd), 32'h00);
    check("async_rst_tick", 32'(tick), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    check("async_rst_hex", 32'(hex), 32'h2040);
    model_reset();
    repeat (2) step();
    rst = 1'b1;

    // Random phase
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      clear = (n < 2);
      load = (n >= 2 && n < 5);
      load_val = 8'($urandom);
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) speed_sel = ~speed_sel;
      if ($urandom_range(0, 15) == 0) begin
        key_up = 1'($urandom_range(0, 1));
        key_down = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
